// File: rtl/pwm_pkg.sv
// Shared widths, mode encoding and packed-bus helper for the PWM counter bank.
package pwm_pkg;

  localparam int CW     = 16;
  localparam int NUM_CH = 4;

  typedef enum logic {
    MODE_CONT    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_e;

  // Channel ch occupies bits [ch*CW +: CW] of every packed per-channel bus.
  function automatic logic [CW-1:0] ch_slice(input logic [NUM_CH*CW-1:0] bus,
                                             input int unsigned ch);
    return bus[ch*CW +: CW];
  endfunction

endpackage

// File: rtl/pwm_chan_cnt.sv
// One channel: period counter, shadowed period, run bit and sticky irq flag.
module pwm_chan_cnt
  import pwm_pkg::*;
(
  input  logic          chosen_clk,
  input  logic          rst,
  input  logic          counter_en,
  input  logic          tick,
  input  logic          start,
  input  logic          clr,
  input  logic          mode_oneshot,
  input  logic          irq_clr,
  input  logic [CW-1:0] period_reg,
  output logic [CW-1:0] counter,
  output logic [CW-1:0] period_act,
  output logic          wrap,
  output logic          irq,
  output logic          irq_next
);

  logic run;
  logic active;
  logic at_end;
  logic hit;

  // A start pulse makes the channel count in the same cycle the enable rises.
  always_comb begin
    active   = run | start;
    at_end   = (period_act != '0) && (counter >= period_act - CW'(1));
    hit      = ~clr & active & counter_en & tick & at_end;
    irq_next = hit | (irq & ~irq_clr);
  end

  always_ff @(posedge chosen_clk) begin
    if (rst) begin
      counter    <= '0;
      period_act <= '0;
      wrap       <= 1'b0;
      run        <= 1'b0;
      irq        <= 1'b0;
    end else begin
      irq  <= irq_next;
      wrap <= 1'b0;
      if (clr) begin
        counter    <= '0;
        period_act <= period_reg;
        run        <= 1'b1;
      end else begin
        if (start)
          run <= 1'b1;
        if (!active) begin
          counter    <= '0;
          period_act <= period_reg;
        end else if (!counter_en) begin
          counter    <= counter;
        end else if (period_act == '0) begin
          counter    <= '0;
          period_act <= period_reg;
        end else if (tick) begin
          // The >= compare also recovers a count stranded above a shrunken period.
          if (at_end) begin
            counter    <= '0;
            wrap       <= 1'b1;
            period_act <= period_reg;
            if (mode_e'(mode_oneshot) == MODE_ONESHOT)
              run <= 1'b0;
          end else begin
            counter <= counter + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/pwm_counter_bank.sv
// Shared prescaler, enable edge detect and irq summary around NUM_CH channel counters.
module pwm_counter_bank #(
  parameter int NUM_CH = pwm_pkg::NUM_CH,
  parameter int CW     = pwm_pkg::CW
) (
  input  logic                 chosen_clk,
  input  logic                 rst,
  input  logic                 counter_en,
  input  logic                 mode_oneshot,
  input  logic                 counter_clr,
  input  logic [CW-1:0]        div_reg,
  input  logic [NUM_CH*CW-1:0] period_reg,
  input  logic [NUM_CH-1:0]    irq_clr,
  output logic [NUM_CH*CW-1:0] counter,
  output logic [NUM_CH*CW-1:0] period_act,
  output logic [NUM_CH-1:0]    wrap,
  output logic [NUM_CH-1:0]    irq,
  output logic                 irq_any
);

  logic [CW-1:0]     pc;
  logic              en_q;
  logic              tick;
  logic              start;
  logic [NUM_CH-1:0] irq_next;

  // >= rather than == so a divisor lowered below the current count ticks at once.
  assign tick  = counter_en & ((div_reg <= CW'(1)) | (pc >= div_reg - CW'(1)));
  assign start = counter_en & ~en_q;

  always_ff @(posedge chosen_clk) begin
    if (rst) begin
      pc      <= '0;
      en_q    <= 1'b0;
      irq_any <= 1'b0;
    end else begin
      en_q    <= counter_en;
      irq_any <= |irq_next;
      if (counter_clr || tick)
        pc <= '0;
      else if (counter_en)
        pc <= pc + CW'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_chan_cnt u_chan (
      .chosen_clk   (chosen_clk),
      .rst          (rst),
      .counter_en   (counter_en),
      .tick         (tick),
      .start        (start),
      .clr          (counter_clr),
      .mode_oneshot (mode_oneshot),
      .irq_clr      (irq_clr[i]),
      .period_reg   (period_reg[i*CW +: CW]),
      .counter      (counter[i*CW +: CW]),
      .period_act   (period_act[i*CW +: CW]),
      .wrap         (wrap[i]),
      .irq          (irq[i]),
      .irq_next     (irq_next[i])
    );
  end

endmodule
